pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter unit for the single-cycle MIPS core. It replaces the
//  bare PC register plus the external branch/jump/jr mux chain. Features: configurable
//  reset and exception vectors, stall hold, prioritised redirect, and misaligned-target
//  trapping. An internal return-address stack (RAS) is pushed by jal and popped by jr.
// PARAMETERS
//  WIDTH      32      PC / address width in bits (>= 8)
//  RESET_VEC  0       PC value loaded on reset
//  EXC_VEC    32'h80  PC value loaded on exception or misaligned redirect
//  RAS_DEPTH  4       return-address stack entries (power of 2, >= 2)
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      asynchronous, active-high
//  stall          in   1      hold PC and RAS this cycle
//  exc            in   1      exception request; go to EXC_VEC
//  branch_taken   in   1      take branch_target
//  branch_target  in   WIDTH  branch destination (PC+4+offset<<2)
//  jump           in   1      take jump_target (j / jal)
//  jump_target    in   WIDTH  {pc_plus4[W-1:28], imm26, 2'b00}
//  call           in   1      jal: push pc_plus4 onto RAS
//  jr             in   1      take jr_target; pop RAS
//  jr_target      in   WIDTH  register rs value
//  pc             out  WIDTH  current PC (registered)
//  pc_plus4       out  WIDTH  pc + 4, modulo 2^WIDTH (combinational)
//  ras_top        out  WIDTH  top RAS entry; 0 when empty
//  ras_empty      out  1      RAS count == 0
//  ras_full       out  1      RAS count == RAS_DEPTH
//  misalign       out  1      registered 1-cycle pulse: redirect target[1:0] != 0
// BEHAVIOUR
//  - Reset (async): pc=RESET_VEC, RAS count=0, pointer=0, entries=0, misalign=0.
//  - Next-PC priority: exc > jr > jump > branch_taken > pc_plus4.
//  - stall=1 and exc=0: pc, RAS and misalign hold. All other inputs are ignored.
//  - exc=1 overrides stall: pc<=EXC_VEC next edge. RAS is unchanged. misalign<=0.
//  - Misaligned check applies to the selected jr/jump/branch target only.
//    If target[1:0]!=0: pc<=EXC_VEC, misalign<=1 for one cycle, RAS push/pop suppressed.
//  - Sequential pc_plus4 wraps: pc=2^WIDTH-4 -> next pc=0. No flag is raised.
//  - One-cycle latency: inputs sampled at edge N take effect as pc after edge N.
//  - RAS is a circular buffer with a write pointer and a saturating count.
//    It updates only when not stalled and the redirect is not trapped.
//    call only: entry[ptr]<=pc_plus4, ptr++, count=min(count+1,RAS_DEPTH).
//      When full, the oldest entry is overwritten.
//    jr only: ptr--, count-- if count>0. When empty: no change, no error.
//    call and jr together: top entry replaced with pc_plus4; ptr and count unchanged.
//      When empty, this behaves as a push.
//  - ras_top=entry[ptr-1] when count>0, else 0. ras_empty and ras_full are
//    combinational from count.
//  - Reset asserted mid-operation: immediate return to reset state, regardless of stall or exc.
// TESTING
//  1 Reset, no redirects, 5 cycles -> pc 0,4,8,12,16. Assert reset at pc=16 -> pc=0 at once.
//  2 pc=8, stall=1 for 3 cycles with jump=1, target=0x40 -> pc stays 8.
//    Release stall -> pc=0x40.
//  3 One cycle with exc, jr(0x100), jump(0x40), branch(0x20) all high -> pc=0x80.
//    Repeat with exc=0 -> pc=0x100. Then exc=1, stall=1 -> pc=0x80.
//  4 pc=0x10, branch_taken, target=0x22 -> pc=0x80, misalign=1 for exactly one cycle.
//    Same trap via jr with call=1 -> RAS count unchanged.
//  5 RAS_DEPTH=4: 5 calls at pc=0,4,8,12,16 -> ras_full=1, ras_top=0x14.
//    4 jr pops -> ras_top 0x10, 0xC, 0x8 (the entry pushed at pc=0 was lost), then ras_empty=1.
//    A 5th pop -> no change.
//  6 WIDTH=16: pc=0xFFFC, no redirect -> pc=0x0000. Simultaneous call+jr with
//    count=2 -> count stays 2, ras_top=new pc_plus4.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the single-cycle MIPS core.
// Selects the next PC (exception > jr > jump > branch > sequential), holds on
// stall, traps misaligned redirect targets to EXC_VEC, and keeps a small
// circular return-address stack pushed by jal and popped by jr.
module pc_sequencer #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] EXC_VEC   = 'h80,
   parameter int               RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             exc,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_target,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misalign
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] r_pc;
   logic             r_misalign;
   logic [WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]    r_ptr;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_target;
   logic             w_redir;
   logic             w_trap;
   logic [WIDTH-1:0] w_pc_next;
   logic             w_ras_en;
   logic [PW-1:0]    w_ptr_m1;
   logic             w_empty;
   logic             w_full;

   assign w_pc_plus4 = r_pc + WIDTH'(4);
   assign w_ptr_m1   = r_ptr - PW'(1);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);

   // Redirect target selection, misalignment trap and next-PC mux
   always_comb begin
      w_target  = branch_target;
      w_redir   = 1'b0;
      if (jr) begin
         w_target = jr_target;
         w_redir  = 1'b1;
      end else if (jump) begin
         w_target = jump_target;
         w_redir  = 1'b1;
      end else if (branch_taken) begin
         w_target = branch_target;
         w_redir  = 1'b1;
      end
      w_trap = w_redir && (w_target[1:0] != 2'b00);
      if (exc || w_trap)
         w_pc_next = EXC_VEC;
      else if (w_redir)
         w_pc_next = w_target;
      else
         w_pc_next = w_pc_plus4;
      // exception and trapped redirects leave the RAS untouched
      w_ras_en = !stall && !exc && !w_trap;
   end

   // PC and misalign flag; exception overrides stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_VEC;
         r_misalign <= 1'b0;
      end else if (exc) begin
         r_pc       <= EXC_VEC;
         r_misalign <= 1'b0;
      end else if (!stall) begin
         r_pc       <= w_pc_next;
         r_misalign <= w_trap;
      end
   end

   // Return-address stack: circular buffer, write pointer, saturating count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
         r_ptr   <= '0;
         r_count <= '0;
      end else if (w_ras_en) begin
         if (call && (!jr || w_empty)) begin
            // push; when full the oldest entry is overwritten
            r_ras[r_ptr] <= w_pc_plus4;
            r_ptr        <= r_ptr + PW'(1);
            if (!w_full) r_count <= r_count + CW'(1);
         end else if (call && jr) begin
            // jal-through-jr: replace top in place
            r_ras[w_ptr_m1] <= w_pc_plus4;
         end else if (jr && !w_empty) begin
            r_ptr   <= w_ptr_m1;
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign pc        = r_pc;
   assign pc_plus4  = w_pc_plus4;
   assign misalign  = r_misalign;
   assign ras_top   = w_empty ? '0 : r_ras[w_ptr_m1];
   assign ras_empty = w_empty;
   assign ras_full  = w_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance for the main scenarios
// and a 16-bit instance for wrap-around and the combined call+jr case.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, reset16, stall, stall16, exc;
   logic        branch_taken, jump, call, jr;
   logic [31:0] branch_target, jump_target, jr_target;

   logic [31:0] pc, pc_plus4, ras_top;
   logic        ras_empty, ras_full, misalign;
   logic [15:0] pc16, pc_plus4_16, ras_top16;
   logic        ras_empty16, ras_full16, misalign16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_sequencer #(.WIDTH(32), .RESET_VEC(32'h0), .EXC_VEC(32'h80), .RAS_DEPTH(4)) u_dut (
      .clk(clk), .reset(reset), .stall(stall), .exc(exc),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .call(call),
      .jr(jr), .jr_target(jr_target),
      .pc(pc), .pc_plus4(pc_plus4), .ras_top(ras_top),
      .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
   );

   pc_sequencer #(.WIDTH(16), .RESET_VEC(16'h0), .EXC_VEC(16'h80), .RAS_DEPTH(4)) u_dut16 (
      .clk(clk), .reset(reset16), .stall(stall16), .exc(exc),
      .branch_taken(branch_taken), .branch_target(branch_target[15:0]),
      .jump(jump), .jump_target(jump_target[15:0]), .call(call),
      .jr(jr), .jr_target(jr_target[15:0]),
      .pc(pc16), .pc_plus4(pc_plus4_16), .ras_top(ras_top16),
      .ras_empty(ras_empty16), .ras_full(ras_full16), .misalign(misalign16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // one rising edge; inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clr();
      exc = 0; branch_taken = 0; jump = 0; call = 0; jr = 0;
      branch_target = 0; jump_target = 0; jr_target = 0;
   endtask

   initial begin
      reset = 1; reset16 = 1; stall = 0; stall16 = 1;
      clr();
      step(); step();
      reset = 0;
      // 1: reset state and sequential fetch
      chk("rst_pc", pc, 32'h0);
      chk("rst_empty", {31'b0, ras_empty}, 32'h1);
      chk("rst_full", {31'b0, ras_full}, 32'h0);
      chk("rst_top", ras_top, 32'h0);
      chk("rst_misalign", {31'b0, misalign}, 32'h0);
      chk("rst_plus4", pc_plus4, 32'h4);
      step(); chk("seq_4", pc, 32'h4);
      step(); chk("seq_8", pc, 32'h8);
      step(); chk("seq_c", pc, 32'hC);
      step(); chk("seq_10", pc, 32'h10);
      reset = 1; #1;
      chk("async_reset", pc, 32'h0);
      @(negedge clk); reset = 0;
      // 2: stall hold with pending jump
      step(); step(); chk("pre_stall", pc, 32'h8);
      stall = 1; jump = 1; jump_target = 32'h40;
      step(); chk("stall_1", pc, 32'h8);
      step(); chk("stall_2", pc, 32'h8);
      step(); chk("stall_3", pc, 32'h8);
      stall = 0;
      step(); chk("stall_release", pc, 32'h40);
      // 3: priority
      clr();
      exc = 1; jr = 1; jr_target = 32'h100; jump = 1; jump_target = 32'h40;
      branch_taken = 1; branch_target = 32'h20;
      step(); chk("prio_exc", pc, 32'h80);
      exc = 0;
      step(); chk("prio_jr", pc, 32'h100);
      chk("jr_pop_empty", {31'b0, ras_empty}, 32'h1);
      exc = 1; stall = 1;
      step(); chk("exc_over_stall", pc, 32'h80);
      clr(); stall = 0;
      // 4: misaligned branch trap
      jump = 1; jump_target = 32'h10;
      step(); chk("pc_10", pc, 32'h10);
      clr(); branch_taken = 1; branch_target = 32'h22;
      step(); chk("mis_br_pc", pc, 32'h80);
      chk("mis_br_flag", {31'b0, misalign}, 32'h1);
      clr();
      step(); chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
      chk("mis_after_pc", pc, 32'h84);
      jump = 1; call = 1; jump_target = 32'h200;
      step(); chk("jal_pc", pc, 32'h200);
      chk("jal_top", ras_top, 32'h88);
      clr(); jr = 1; call = 1; jr_target = 32'h103;
      step(); chk("mis_jr_pc", pc, 32'h80);
      chk("mis_jr_flag", {31'b0, misalign}, 32'h1);
      chk("mis_jr_top", ras_top, 32'h88);
      clr(); jr = 1; jr_target = 32'h300;
      step(); chk("pop_one_pc", pc, 32'h300);
      chk("pop_one_empty", {31'b0, ras_empty}, 32'h1);
      clr();
      // 5: RAS overflow and underflow
      reset = 1; #1; @(negedge clk); reset = 0;
      call = 1;
      step(); step(); step(); step();
      chk("four_full", {31'b0, ras_full}, 32'h1);
      step();
      chk("five_full", {31'b0, ras_full}, 32'h1);
      chk("five_top", ras_top, 32'h14);
      chk("five_pc", pc, 32'h14);
      clr(); jr = 1; jr_target = 32'h40;
      step(); chk("pop1_top", ras_top, 32'h10);
      chk("pop1_full", {31'b0, ras_full}, 32'h0);
      step(); chk("pop2_top", ras_top, 32'hC);
      step(); chk("pop3_top", ras_top, 32'h8);
      step(); chk("pop4_empty", {31'b0, ras_empty}, 32'h1);
      chk("pop4_top", ras_top, 32'h0);
      step(); chk("pop5_empty", {31'b0, ras_empty}, 32'h1);
      chk("pop5_top", ras_top, 32'h0);
      chk("pop5_pc", pc, 32'h40);
      clr();
      // 6: 16-bit wrap and simultaneous call+jr
      stall = 1; reset16 = 0; stall16 = 0;
      chk("w16_rst", {16'b0, pc16}, 32'h0);
      jump = 1; jump_target = 32'hFFFC;
      step(); chk("w16_fffc", {16'b0, pc16}, 32'hFFFC);
      chk("w16_plus4", {16'b0, pc_plus4_16}, 32'h0);
      clr();
      step(); chk("w16_wrap", {16'b0, pc16}, 32'h0);
      chk("w16_nomis", {31'b0, misalign16}, 32'h0);
      call = 1;
      step(); step(); chk("w16_top2", {16'b0, ras_top16}, 32'h8);
      jr = 1; jr_target = 32'h100;
      step(); chk("w16_cj_top", {16'b0, ras_top16}, 32'hC);
      chk("w16_cj_pc", {16'b0, pc16}, 32'h100);
      chk("w16_cj_full", {31'b0, ras_full16}, 32'h0);
      clr(); jr = 1; jr_target = 32'h200;
      step(); chk("w16_pop1_top", {16'b0, ras_top16}, 32'h4);
      chk("w16_pop1_empty", {31'b0, ras_empty16}, 32'h0);
      step(); chk("w16_pop2_empty", {31'b0, ras_empty16}, 32'h1);
      chk("w32_held", pc, 32'h40);
      clr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
